// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared constants and types for the image point-operation engine
//
// Purpose: colour byte width, per-port op modes, output source tags and the
// default BMP header length shared by the accelerator and its byte operator.
package img_proc_pkg;

  localparam int COLOR_SIZE       = 8;
  localparam int HEADER_BYTES_DEF = 54;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_BRIGHTEN = 2'b01,
    MODE_DARKEN   = 2'b10,
    MODE_END      = 2'b11
  } mode_e;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_SLV0 = 2'b01;
  localparam logic [1:0] SRC_SLV1 = 2'b10;

endpackage

// File: rtl/pixel_byte_op.sv
// rtl/pixel_byte_op.sv - combinational saturating brighten/darken of one colour byte
//
// Ports:
//   byte_in   colour byte from the selected input lane
//   proc_val  brighten/darken operand
//   mode      op select (bypass, brighten, darken; end-of-image behaves as bypass)
//   is_header lane belongs to the BMP header and must pass untouched
//   byte_out  resulting byte
module pixel_byte_op
  import img_proc_pkg::*;
(
  input  logic [COLOR_SIZE-1:0] byte_in,
  input  logic [COLOR_SIZE-1:0] proc_val,
  input  mode_e                 mode,
  input  logic                  is_header,
  output logic [COLOR_SIZE-1:0] byte_out
);

  // One extra bit catches the carry (brighten) or the borrow (darken).
  logic [COLOR_SIZE:0] sum;
  logic [COLOR_SIZE:0] diff;

  always_comb begin
    sum      = {1'b0, byte_in} + {1'b0, proc_val};
    diff     = {1'b0, byte_in} - {1'b0, proc_val};
    byte_out = byte_in;
    if (!is_header) begin
      case (mode)
        MODE_BRIGHTEN: byte_out = sum[COLOR_SIZE]  ? '1 : sum[COLOR_SIZE-1:0];
        MODE_DARKEN:   byte_out = diff[COLOR_SIZE] ? '0 : diff[COLOR_SIZE-1:0];
        default:       byte_out = byte_in;
      endcase
    end
  end

endmodule

// File: rtl/image_processing_accelerator.sv
// rtl/image_processing_accelerator.sv - two-port BMP byte-stream point-operation engine
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   slvN_mode/_data_valid/_proc_val/_data/_ready   input ports 0 and 1
//   mstr0_data, mstr0_data_valid     registered output word and source tag
//   mstr0_ready                      downstream accept
//   mstr0_cmplt                      one-cycle end-of-image pulse
module image_processing_accelerator
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int HEADER_BYTES = HEADER_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            slv0_mode,
  input  logic                  slv0_data_valid,
  input  logic [COLOR_SIZE-1:0] slv0_proc_val,
  input  logic [DATA_WIDTH-1:0] slv0_data,
  output logic                  slv0_ready,
  input  logic [1:0]            slv1_mode,
  input  logic                  slv1_data_valid,
  input  logic [COLOR_SIZE-1:0] slv1_proc_val,
  input  logic [DATA_WIDTH-1:0] slv1_data,
  output logic                  slv1_ready,
  output logic                  mstr0_cmplt,
  input  logic                  mstr0_ready,
  output logic [DATA_WIDTH-1:0] mstr0_data,
  output logic [1:0]            mstr0_data_valid
);

  localparam int          LANES = DATA_WIDTH / COLOR_SIZE;
  localparam logic [31:0] STEP  = 32'(LANES);
  localparam logic [31:0] HDR   = 32'(HEADER_BYTES);

  logic [31:0]           cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]            prev0_q, prev0_d, prev1_q, prev1_d;
  logic                  cmplt_q, cmplt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            tag_q, tag_d;

  logic                  adv, end0, end1, acc0, acc1;
  logic [DATA_WIDTH-1:0] sel_data, proc_word;
  logic [COLOR_SIZE-1:0] sel_proc;
  mode_e                 sel_mode;
  logic [31:0]           sel_cnt;

  // Counter advance saturates at the header length: past the header every
  // lane is pixel data, so the exact index no longer matters.
  function automatic logic [31:0] cnt_next(logic [31:0] cnt, logic acc, logic is_end);
    if (is_end)                  return '0;
    else if (!acc)               return cnt;
    else if (cnt + STEP >= HDR)  return HDR;
    else                         return cnt + STEP;
  endfunction

  always_comb begin
    adv        = (tag_q == SRC_NONE) | mstr0_ready;
    end0       = slv0_mode == MODE_END;
    end1       = slv1_mode == MODE_END;
    slv0_ready = adv & ~end0;
    slv1_ready = adv & ~end1 & ~(slv0_data_valid & ~end0);
    acc0       = slv0_data_valid & slv0_ready;
    acc1       = slv1_data_valid & slv1_ready;
    // acc0 and acc1 are mutually exclusive, so port 1 is picked only on its own accept.
    sel_data   = acc1 ? slv1_data : slv0_data;
    sel_proc   = acc1 ? slv1_proc_val : slv0_proc_val;
    sel_mode   = acc1 ? mode_e'(slv1_mode) : mode_e'(slv0_mode);
    sel_cnt    = acc1 ? cnt1_q : cnt0_q;
  end

  // Lane 0 (file byte cnt) sits in the most significant byte.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic lane_hdr;
    assign lane_hdr = (sel_cnt + 32'(k)) < HDR;
    pixel_byte_op u_op (
      .byte_in   (sel_data[DATA_WIDTH-1-COLOR_SIZE*k -: COLOR_SIZE]),
      .proc_val  (sel_proc),
      .mode      (sel_mode),
      .is_header (lane_hdr),
      .byte_out  (proc_word[DATA_WIDTH-1-COLOR_SIZE*k -: COLOR_SIZE])
    );
  end

  always_comb begin
    cnt0_d  = cnt_next(cnt0_q, acc0, end0);
    cnt1_d  = cnt_next(cnt1_q, acc1, end1);
    prev0_d = slv0_mode;
    prev1_d = slv1_mode;
    // Either port rising into end-of-image gives one shared pulse.
    cmplt_d = (end0 & (prev0_q != MODE_END)) | (end1 & (prev1_q != MODE_END));
    data_d  = data_q;
    tag_d   = tag_q;
    if (adv) begin
      tag_d = acc0 ? SRC_SLV0 : (acc1 ? SRC_SLV1 : SRC_NONE);
      if (acc0 | acc1) data_d = proc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      prev0_q <= MODE_BYPASS;
      prev1_q <= MODE_BYPASS;
      cmplt_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= SRC_NONE;
    end else begin
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      prev0_q <= prev0_d;
      prev1_q <= prev1_d;
      cmplt_q <= cmplt_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign mstr0_cmplt      = cmplt_q;
  assign mstr0_data       = data_q;
  assign mstr0_data_valid = tag_q;

endmodule

// File: tb/tb_image_processing_accelerator.sv
// tb/tb_image_processing_accelerator.sv - self-checking bench for image_processing_accelerator
module tb_image_processing_accelerator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m0, m1;
  logic        v0, v1, r0, r1, mr, cmplt;
  logic [7:0]  p0, p1;
  logic [31:0] d0, d1, od;
  logic [1:0]  otag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: file byte index per port, last mode seen, output register.
  int          ref_cnt0, ref_cnt1, ref_prev0, ref_prev1, ref_tag, ref_cmplt;
  logic [31:0] ref_data;

  always #5 clk = ~clk;

  image_processing_accelerator dut (
    .clk(clk), .rst_n(rst_n),
    .slv0_mode(m0), .slv0_data_valid(v0), .slv0_proc_val(p0), .slv0_data(d0), .slv0_ready(r0),
    .slv1_mode(m1), .slv1_data_valid(v1), .slv1_proc_val(p1), .slv1_data(d1), .slv1_ready(r1),
    .mstr0_cmplt(cmplt), .mstr0_ready(mr), .mstr0_data(od), .mstr0_data_valid(otag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // File byte i is processed only once i >= 54; arithmetic is plain integer with clamping.
  function automatic logic [31:0] ref_word(logic [31:0] w, int mode, int p, int cnt);
    logic [31:0] r;
    int b;
    r = w;
    for (int k = 0; k < 4; k++) begin
      b = int'(w[31-8*k -: 8]);
      if (cnt + k >= 54) begin
        if (mode == 1)      b = (b + p > 255) ? 255 : b + p;
        else if (mode == 2) b = (b < p) ? 0 : b - p;
      end
      r[31-8*k -: 8] = 8'(b);
    end
    return r;
  endfunction

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    bit adv, er0, er1, a0, a1;
    #1;
    adv = (ref_tag == 0) || mr;
    er0 = adv && (m0 != 2'b11);
    er1 = adv && (m1 != 2'b11) && !(v0 && m0 != 2'b11);
    chk("slv0_ready", 32'(r0), 32'(er0));
    chk("slv1_ready", 32'(r1), 32'(er1));
    @(posedge clk);
    if (!rst_n) begin
      ref_cnt0 = 0; ref_cnt1 = 0; ref_prev0 = 0; ref_prev1 = 0;
      ref_tag = 0; ref_cmplt = 0; ref_data = '0;
    end else begin
      a0 = v0 && er0;
      a1 = v1 && er1;
      if (adv) begin
        if (a0)      begin ref_data = ref_word(d0, int'(m0), int'(p0), ref_cnt0); ref_tag = 1; end
        else if (a1) begin ref_data = ref_word(d1, int'(m1), int'(p1), ref_cnt1); ref_tag = 2; end
        else ref_tag = 0;
      end
      if (m0 == 2'b11) ref_cnt0 = 0; else if (a0) ref_cnt0 = (ref_cnt0 + 4 > 54) ? 54 : ref_cnt0 + 4;
      if (m1 == 2'b11) ref_cnt1 = 0; else if (a1) ref_cnt1 = (ref_cnt1 + 4 > 54) ? 54 : ref_cnt1 + 4;
      ref_cmplt = int'((m0 == 2'b11 && ref_prev0 != 3) || (m1 == 2'b11 && ref_prev1 != 3));
      ref_prev0 = int'(m0);
      ref_prev1 = int'(m1);
    end
    #1;
    chk("out_tag", 32'(otag), 32'(ref_tag));
    chk("cmplt", 32'(cmplt), 32'(ref_cmplt));
    if (ref_tag != 0) chk("out_data", od, ref_data);
    @(negedge clk);
  endtask

  logic [31:0] hold;

  initial begin
    rst_n = 1'b0; mr = 1'b1;
    m0 = 2'b00; m1 = 2'b00; p0 = 8'h00; p1 = 8'h00;
    v0 = 1'b1; v1 = 1'b1; d0 = 32'hDEADBEEF; d1 = 32'hCAFEF00D;
    ref_cnt0 = 0; ref_cnt1 = 0; ref_prev0 = 0; ref_prev1 = 0;
    ref_tag = 0; ref_cmplt = 0; ref_data = '0;
    @(negedge clk);
    step(); step();
    chk("rst_data", od, 32'h0);
    chk("rst_tag", 32'(otag), 32'h0);
    chk("rst_cmplt", 32'(cmplt), 32'h0);

    // Darken across the header boundary.
    rst_n = 1'b1; v1 = 1'b0; m0 = 2'b10; p0 = 8'h0A;
    for (int i = 0; i < 13; i++) begin
      d0 = $urandom;
      step();
      chk("hdr_echo", od, d0);
    end
    d0 = 32'h12345678; step(); chk("dark_52", od, 32'h12344C6E);
    d0 = 32'h10F8FF00; step(); chk("dark_56", od, 32'h06EEF500);

    // End of image: single pulse, port blocked, counter cleared.
    m0 = 2'b11; step(); chk("cmplt_pulse", 32'(cmplt), 32'h1);
    step(); chk("cmplt_once", 32'(cmplt), 32'h0);

    m0 = 2'b01;
    for (int i = 0; i < 14; i++) begin d0 = $urandom; step(); end
    d0 = 32'h10F8FF00; step(); chk("bright", od, 32'h1AFFFF0A);

    // Arbitration then backpressure.
    m0 = 2'b00; v1 = 1'b1; d1 = 32'h0BADF00D; d0 = 32'h11223344;
    step(); chk("arb_tag0", 32'(otag), 32'h1);
    v0 = 1'b0; step(); chk("arb_tag1", 32'(otag), 32'h2); chk("arb_data1", od, 32'h0BADF00D);
    v1 = 1'b0; v0 = 1'b1; mr = 1'b0; hold = od;
    for (int i = 0; i < 3; i++) begin d0 = $urandom; step(); chk("bp_hold", od, hold); end
    mr = 1'b1; step(); step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 127) != 0);
      m0 = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      m1 = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v0 = 1'($urandom); v1 = 1'($urandom);
      p0 = 8'($urandom); p1 = 8'($urandom);
      d0 = $urandom; d1 = $urandom;
      mr = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_processing_accelerator.md
# image_processing_accelerator

Streaming per-byte image point-operation engine for BMP pixel data. It has two slave input ports (slv0, slv1), each carrying packed BMP file bytes with its own mode and operand. It arbitrates between them, applies a saturating brighten/darken (or bypass) to pixel bytes, passes BMP header bytes through unchanged, and forwards results on one master output port tagged with the source port.

## Interface
- DATA_WIDTH, 32: data bus width in bits; must be a multiple of 8.
- COLOR_SIZE, 8: width of one colour byte and of `proc_val`; shared constant.
- HEADER_BYTES, 54: leading bytes per image passed through unprocessed.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- slv0_mode  in  2  op select: 00 bypass, 01 brighten, 10 darken, 11 end-of-image.
- slv0_data_valid  in  1  slv0 word valid.
- slv0_proc_val  in  COLOR_SIZE  operand for brighten/darken.
- slv0_data  in  DATA_WIDTH  packed bytes; lower file byte index in higher lane (byte k of word at [DATA_WIDTH-1-8k -: 8]).
- slv0_ready  out  1  slv0 word accepted this cycle when valid & ready.
- slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data, slv1_ready: same as slv0, for port 1.
- mstr0_cmplt  out  1  one-cycle end-of-image pulse.
- mstr0_ready  in  1  downstream accepts output.
- mstr0_data  out  DATA_WIDTH  processed word.
- mstr0_data_valid  out  2  source tag: 00 none, 01 from slv0, 10 from slv1; 11 never driven.

## Operation
- Per-port byte counter `cnt` (32 bit) holds the file byte index of the next word's lane 0. It advances by DATA_WIDTH/8 per accepted word and saturates at HEADER_BYTES.
- Per lane k: if cnt+k < HEADER_BYTES, the byte passes unchanged. Otherwise the mode is applied:
  - 00: unchanged.
  - 01: min(b + proc_val, 255).
  - 10: max(b − proc_val, 0).
- Arithmetic uses COLOR_SIZE+1 bits before clamping.
- Mode 11 on a port:
  - No data is accepted from that port; its ready is 0.
  - The port's counter clears to 0.
  - mstr0_cmplt pulses for one cycle on the first cycle mode 11 is sampled, i.e. on the rising transition from a non-11 mode. It does not pulse again while the mode stays 11.
  - If both ports transition to 11 in the same cycle, a single pulse is produced.
- Arbitration: fixed priority to slv0. slv1_ready is 0 in any cycle where slv0 is valid and not in mode 11.
- Output stage is a single register. `adv = (mstr0_data_valid == 00) | mstr0_ready`.
  - slv0_ready = adv & slv0_mode != 11.
  - slv1_ready = adv & slv1_mode != 11 & !(slv0_data_valid & slv0_mode != 11).
- When adv is high, the output register loads the accepted word and tag, or tag 00 if nothing was accepted. When adv is low, data and tag hold.

## Timing
- Reset (rst_n low at a clk edge):
  - mstr0_data = 0, mstr0_data_valid = 00, mstr0_cmplt = 0.
  - Both counters = 0; previous-mode trackers = 00.
  - The ready outputs are combinational and may be high during reset, but no transfer is recorded while rst_n = 0.
- Latency: one cycle from accept edge to output valid. Full throughput is one word per cycle while mstr0_ready = 1.
- mstr0_ready low: the output holds stable and valid, and both readies drop (backpressure).
- Reset mid-stream: the in-flight output is discarded and counters restart at 0.
- A mode change takes effect on the next accepted word. The counter is unaffected except by mode 11.

## Structure
- Package `img_proc_pkg`: COLOR_SIZE, mode enum (MODE_BYPASS, MODE_BRIGHTEN, MODE_DARKEN, MODE_END), source-tag constants (SRC_NONE, SRC_SLV0, SRC_SLV1), HEADER_BYTES default.
- One sub-module `pixel_byte_op`: combinational per-byte op (byte, proc_val, mode, is_header) → byte. Instantiated DATA_WIDTH/8 times for the selected port.
- Top level contains arbitration, counters, the cmplt edge detector and the output register.

## Test plan
- Reset with both ports valid → outputs 0/00/0. First word after rst_n rises appears one cycle after acceptance.
- slv0 mode 01, proc 0x0A, 14 header words then 0x10F8FF00 → header words echoed unchanged with tag 01; next word 0x1AFFFF0A.
- slv0 mode 10, proc 0x0A, word at byte index 52 = 0x12345678 → 0x1234# (lanes 0,1 pass) = 0x12344C6E; next word 0x10F8FF00 → 0x06EEF500.
- Both ports valid on the same cycle → slv0 accepted (tag 01), slv1_ready = 0. Once slv0 goes idle, the slv1 word is output with tag 10.
- mstr0_ready held low 3 cycles with output valid → data/tag stable, readies 0. On release, stream resumes with no loss or duplication.
- slv0 mode switches 10→11 → one-cycle mstr0_cmplt pulse, slv0_ready = 0. A subsequent word in mode 01 is treated as header again (counter cleared).
